// File: rtl/serial_add_ctrl_if.sv
// Request/response bundle for the bit-serial adder controller.
// Both channels use valid/ready: a transfer happens on a rising clk edge
// where valid and ready are both high; the sender holds valid and its
// payload stable until that edge, and valid never drops without ready.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 4
);
    // Operand request channel (requester -> controller)
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;

    // Result channel (controller -> requester)
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

    // Requester side
    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_cout
    );

    // Controller side
    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial addition controller. Sequences one external registered
// 1-bit full adder LSB first: operand bit cnt is presented in RUN, its
// registered sum comes back one cycle later and lands in sum_q[cnt-1].
// The adder's registered carry is fed straight back as the next carry_in.
// A final DRAIN cycle collects the MSB sum and the carry-out.
// dbg_state exposes the FSM encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3).
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rstn,
    serial_add_ctrl_if.slave    bus,
    output logic                fa_a,
    output logic                fa_b,
    output logic                fa_cin,
    input  logic                fa_sum,
    input  logic                fa_cout,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cin_q, cin_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_c;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state, datapath updates and adder pin drive.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
        in_ready_c  = 1'b0;
        fa_a        = 1'b0;
        fa_b        = 1'b0;
        fa_cin      = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    cin_d   = bus.in_cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                fa_a   = a_q[cnt_q];
                fa_b   = b_q[cnt_q];
                // Bit 0 uses the requester's carry; later bits use the
                // adder's registered carry from the previous bit.
                fa_cin = (cnt_q == '0) ? cin_q : fa_cout;
                // The adder output now belongs to the bit presented last cycle.
                if (cnt_q != '0) begin
                    sum_d[cnt_q - CNT_ONE] = fa_sum;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            DRAIN: begin
                // Adder pins stay 0; only collect the last bit and the carry.
                sum_d[WIDTH-1] = fa_sum;
                cout_d         = fa_cout;
                out_valid_d    = 1'b1;
                state_d        = DONE;
            end

            DONE: begin
                // Result held stable until the consumer takes it.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign busy          = (state_q != IDLE);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a behavioural registered full adder.
module tb_serial_add_ctrl;
    localparam int WIDTH = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       fa_a, fa_b, fa_cin;
    logic       fa_sum, fa_cout;
    logic       busy;
    logic [1:0] dbg_state;

    int n_pass  = 0;
    int n_total = 0;
    int lat;
    int busy_n;
    logic cin_log [0:15];

    // Clock
    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_cin    (fa_cin),
        .fa_sum    (fa_sum),
        .fa_cout   (fa_cout),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // External registered full adder sharing clk/rstn
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fa_sum  <= 1'b0;
            fa_cout <= 1'b0;
        end else begin
            {fa_cout, fa_sum} <= {1'b0, fa_a} + {1'b0, fa_b} + {1'b0, fa_cin};
        end
    end

    // Watchdog
    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=still_running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while (!bus.in_ready && g < 50) begin
            tick();
            g++;
        end
        if (g >= 50) check({tag, "_ready_timeout"}, 32'(bus.in_ready), 32'd1);
    endtask

    // One full transaction; stall = cycles out_ready is held low in DONE.
    task automatic op(input logic [3:0] a, input logic [3:0] b, input logic cin,
                      input logic [4:0] exp, input int stall, input bit full,
                      input string tag);
        wait_idle(tag);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        tick();                      // accept edge E0
        bus.in_valid = 1'b0;
        busy_n     = busy ? 1 : 0;
        lat        = 0;
        cin_log[0] = fa_cin;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
            if (busy) busy_n++;
            if (lat < 16) cin_log[lat] = fa_cin;
        end
        if (full) check({tag, "_latency"}, 32'(lat), 32'(WIDTH + 1));
        check({tag, "_result"}, 32'({bus.out_cout, bus.out_sum}), 32'(exp));
        if (stall > 0) begin
            bus.out_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                tick();
                if (busy) busy_n++;
                if (full) begin
                    check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
                    check({tag, "_hold_result"}, 32'({bus.out_cout, bus.out_sum}), 32'(exp));
                end
            end
            bus.out_ready = 1'b1;
        end
        tick();                      // release edge
        if (full) begin
            check({tag, "_valid_pulse"}, 32'(bus.out_valid), 32'd0);
            check({tag, "_in_ready_after"}, 32'(bus.in_ready), 32'd1);
        end
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(WIDTH + 2 + stall));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b1;

        // Reset values
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_sum",   32'(bus.out_sum),   32'd0);
        check("rst_out_cout",  32'(bus.out_cout),  32'd0);
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_fa_pins",   32'({fa_a, fa_b, fa_cin}), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_state",     32'(dbg_state),     32'd0);
        rstn = 1'b1;
        tick();

        // 1: 5 + 3
        op(4'h5, 4'h3, 1'b0, 5'h08, 0, 1'b1, "t1_5p3");

        // 2: carry ripple
        op(4'hF, 4'h1, 1'b0, 5'h10, 0, 1'b1, "t2_Fp1");
        check("t2_fa_cin_cnt0", 32'(cin_log[0]), 32'd0);
        check("t2_fa_cin_cnt1", 32'(cin_log[1]), 32'd1);
        check("t2_fa_cin_cnt2", 32'(cin_log[2]), 32'd1);
        check("t2_fa_cin_cnt3", 32'(cin_log[3]), 32'd1);
        op(4'hF, 4'hF, 1'b1, 5'h1F, 0, 1'b1, "t2_FpFp1");

        // 3: backpressure
        op(4'hA, 4'h6, 1'b0, 5'h10, 10, 1'b1, "t3_stall");

        // 4: in_valid held while busy, operands changed mid-run
        wait_idle("t4");
        bus.in_valid = 1'b1;
        bus.in_a     = 4'h1;
        bus.in_b     = 4'h1;
        bus.in_cin   = 1'b0;
        tick();                      // first pair accepted
        tick();
        check("t4_in_ready_busy", 32'(bus.in_ready), 32'd0);
        tick();
        bus.in_a = 4'h2;
        bus.in_b = 4'h2;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("t4_first_result", 32'({bus.out_cout, bus.out_sum}), 32'h02);
        tick();                      // release, back to IDLE
        check("t4_idle_busy",    32'(busy),         32'd0);
        check("t4_idle_ready",   32'(bus.in_ready), 32'd1);
        tick();                      // second pair accepted
        bus.in_valid = 1'b0;
        check("t4_second_busy",  32'(busy),         32'd1);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("t4_second_result", 32'({bus.out_cout, bus.out_sum}), 32'h04);
        tick();

        // 5: asynchronous reset at cnt=2
        wait_idle("t5");
        bus.in_valid = 1'b1;
        bus.in_a     = 4'h7;
        bus.in_b     = 4'h7;
        bus.in_cin   = 1'b0;
        tick();                      // cnt=0
        bus.in_valid = 1'b0;
        tick();                      // cnt=1
        tick();                      // cnt=2
        check("t5_pre_state", 32'(dbg_state), 32'd1);
        check("t5_pre_fa_a",  32'(fa_a),      32'd1);
        rstn = 1'b0;
        #1;
        check("t5_rst_busy",      32'(busy),          32'd0);
        check("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("t5_rst_fa_pins",   32'({fa_a, fa_b, fa_cin}), 32'd0);
        check("t5_rst_state",     32'(dbg_state),     32'd0);
        tick();
        rstn = 1'b1;
        tick();
        tick();
        check("t5_no_result", 32'(bus.out_valid), 32'd0);
        op(4'h3, 4'h4, 1'b0, 5'h07, 0, 1'b1, "t5_3p4");

        // 6: exhaustive sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    op(4'(a), 4'(b), 1'(c), 5'(a + b + c), 0, 1'b0,
                       $sformatf("sweep_%0h_%0h_%0d", a, b, c));
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial addition controller that sequences the team's registered 1-bit full_adder to add two WIDTH-bit operands, LSB first, one bit per cycle. It takes operands over a valid/ready handshake and drives the adder's a/b/carry_in pins. It feeds the adder's carry back as the next carry_in, collects sum bits, and returns the WIDTH-bit sum plus carry-out over a second valid/ready handshake. It sits between a requester and one external full_adder instance, which shares clk/rstn with it.

Parameters:
WIDTH, 4, operand/result width in bits; legal range 1..32.

Ports:
clk  in  1  single clock, rising edge
rstn  in  1  asynchronous active-low reset
in_valid  in  1  operand request valid
in_ready  out  1  controller can accept operands
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_cin  in  1  initial carry-in
fa_a  out  1  adder input a
fa_b  out  1  adder input b
fa_cin  out  1  adder carry_in
fa_sum  in  1  adder registered sum (valid 1 cycle after inputs)
fa_cout  in  1  adder registered carry-out (valid 1 cycle after inputs)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_sum  out  WIDTH  result sum
out_cout  out  1  result carry-out
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rstn). Assertion forces IDLE immediately, regardless of clock.
- Reset values: out_valid=0, out_sum=0, out_cout=0, busy=0, fa_a/fa_b/fa_cin=0, bit counter=0, operand registers=0. in_ready=1 once in IDLE.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=1. On an edge with in_valid&in_ready, register in_a, in_b and in_cin, clear cnt, and go to RUN. in_valid in any other state is ignored, because in_ready=0.
- RUN (WIDTH cycles, cnt=0..WIDTH-1):
  - fa_a=a_reg[cnt], fa_b=b_reg[cnt].
  - fa_cin=cin_reg when cnt==0, otherwise fa_cout (combinational feedback of the previous bit's registered carry).
  - When cnt>=1, capture fa_sum into sum_reg[cnt-1] on each edge.
  - On the edge where cnt==WIDTH-1, go to DRAIN.
- DRAIN (1 cycle): fa_a/fa_b/fa_cin=0. On the edge, capture fa_sum into sum_reg[WIDTH-1] and fa_cout into out_cout, set out_valid=1, and go to DONE.
- DONE: out_valid=1. out_sum and out_cout stay stable until out_valid&out_ready. On that edge, out_valid=0 and the FSM returns to IDLE. There is no overlap with new input in the same cycle.
- Outside RUN, fa_a/fa_b/fa_cin are driven 0.
- Latency: with the accept edge as E0, out_valid is high from E(WIDTH+1). Sum bit k is captured at E(k+2). Throughput is one operation per WIDTH+3 cycles minimum, with out_ready tied high.
- Arithmetic: {out_cout,out_sum} = in_a + in_b + in_cin, modulo 2^(WIDTH+1). The result is exact; no overflow flag is produced.
- WIDTH=1: RUN lasts one cycle, then DRAIN. Same rules apply.
- Counter: width max(1,clog2(WIDTH)). It never wraps; the FSM leaves RUN at WIDTH-1.
- Reset mid-operation, in any state: abort, discard partial sum, out_valid=0, return to IDLE. No result is emitted.
- out_ready held high before DONE has no effect. out_valid never drops without out_ready.

Test Plan:
1. WIDTH=4, in_a=0x5, in_b=0x3, in_cin=0, out_ready=1 -> out_valid at E5; out_sum=0x8, out_cout=0; out_valid is a 1-cycle pulse; then in_ready=1.
2. in_a=0xF, in_b=0x1, in_cin=0 -> out_sum=0x0, out_cout=1. Then in_a=0xF, in_b=0xF, in_cin=1 -> out_sum=0xF, out_cout=1. Check fa_cin=1 for cnt=1..3 in the first case.
3. Backpressure: 0xA+0x6, out_ready=0 for 10 cycles -> out_valid held with out_sum=0x0, out_cout=1 unchanged. Assert out_ready -> release on the next edge, then in_ready=1.
4. in_valid held high with 0x1+0x1 while busy, then changed to 0x2+0x2 mid-run -> the second operand pair is not accepted until IDLE. The first result is 0x2; the second, accepted after return to IDLE, is 0x4.
5. Assert rstn=0 asynchronously at cnt=2 during 0x7+0x7 -> immediately busy=0, out_valid=0, fa_*=0. After release, a new 0x3+0x4 yields 0x7 with cout 0.
6. Exhaustive sweep, WIDTH=4: all a, b in 0..15 and cin in {0,1} -> {out_cout,out_sum}=a+b+cin. Per operation: busy is high for exactly WIDTH+2 cycles plus stall cycles.
